mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 23, memory address width; matches the MMU ram_A width.
REQ-002 Parameter STARVE_MAX, default 8, number of non-loader grants after which a pending loader request is promoted above the CPU.
REQ-003 Ports are as follows; clock CLK, reset reset, synchronous, active-high.
REQ-004 CLK  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 vid_req  in  1  one-cycle video read request pulse.
REQ-007 vid_addr  in  AW  video address.
REQ-008 vid_ack  out  1  one-cycle video completion pulse.
REQ-009 vid_dout  out  8  video read data.
REQ-010 cpu_req  in  1  one-cycle CPU request pulse.
REQ-011 cpu_we  in  1  CPU write enable.
REQ-012 cpu_addr  in  AW  CPU address, taken from the MMU ram_A output.
REQ-013 cpu_din  in  8  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle CPU completion pulse.
REQ-015 cpu_dout  out  8  CPU read data.
REQ-016 ld_req  in  1  one-cycle loader write request pulse.
REQ-017 ld_addr  in  AW  loader address.
REQ-018 ld_din  in  8  loader write data.
REQ-019 ld_ack  out  1  one-cycle loader completion pulse.
REQ-020 mem_req  out  1  memory request, level.
REQ-021 mem_we  out  1  memory write enable.
REQ-022 mem_addr  out  AW  memory address.
REQ-023 mem_din  out  8  memory write data.
REQ-024 mem_dout  in  8  memory read data.
REQ-025 mem_ready  in  1  memory completion pulse.

Function
REQ-026 A *_req pulse SHALL, on the next edge, set that requester's pending flag and latch its address, data and we; a pulse arriving while the flag is already set SHALL be ignored (no queue).
REQ-027 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-028 In IDLE with any flag pending, the next edge SHALL enter BUSY, clear the winner's flag, assert mem_req, and drive mem_addr/mem_we/mem_din from the winner's latched values.
REQ-029 Priority SHALL be video > CPU > loader, except that a loader with starve_cnt >= STARVE_MAX SHALL beat the CPU; the loader SHALL never beat video.
REQ-030 Video SHALL always read (mem_we=0), and the loader SHALL always write (mem_we=1).
REQ-031 In BUSY, mem_req and all mem_* outputs SHALL be held stable until mem_ready=1 is sampled.
REQ-032 When mem_ready=1 is sampled in BUSY, the next edge SHALL deassert mem_req, return to IDLE, pulse the winner's ack for 1 cycle, and, for reads, register mem_dout into the winner's dout.
REQ-033 The minimum latency from a req pulse at cycle N SHALL be mem_req high at N+2, with the earliest ack one cycle after mem_ready.
REQ-034 mem_ready SHALL be ignored in IDLE.
REQ-035 dout SHALL hold its last value until the next read completion for that requester.
REQ-036 starve_cnt SHALL increment (saturating at STARVE_MAX) on each video or CPU grant while the loader is pending, and SHALL clear when the loader is granted.
REQ-037 A req pulse arriving in the same cycle as that requester's ack SHALL be accepted as a new request.

Reset
REQ-038 On reset, all pending flags, acks, mem_req, mem_we and starve_cnt SHALL be 0, the state SHALL be IDLE, and mem_addr, mem_din and dout SHALL be 0.
REQ-039 Reset during BUSY SHALL drop mem_req on the next edge and SHALL issue no ack for the abandoned request.

Configuration
REQ-040 Macro MEM_ARB_LOADER_EN: when defined, the loader port and the starvation logic SHALL be present.
REQ-041 When MEM_ARB_LOADER_EN is undefined, ld_req SHALL be ignored, ld_ack SHALL be tied to 0, starve_cnt SHALL be removed, and priority SHALL be video > CPU.

Structure
REQ-042 Package amstrad_mem_pkg SHALL hold the requester enum (REQ_VID, REQ_CPU, REQ_LD), the FSM state typedef, and the default AW/data-width constants.
REQ-043 The combinational winner select SHALL be implemented in a sub-module mem_arb_prio (inputs: pending flags and the starve flag; output: one-hot grant).

Verification
REQ-044 Bench SHALL check that cpu_req with cpu_addr=0x008123, cpu_we=0, and mem_ready 3 cycles after mem_req with mem_dout=0x5A produces cpu_ack exactly once with cpu_dout=0x5A.
REQ-045 Bench SHALL check that vid_req and cpu_req pulsed in the same cycle produce a video grant first, then the CPU grant; the two acks SHALL never coincide.
REQ-046 Bench SHALL check that, with STARVE_MAX=8, a pending loader plus continuous CPU requests yields a loader grant after the 8th CPU grant, with mem_we=1 and mem_din=ld_din.
REQ-047 Bench SHALL check that reset asserted while mem_req=1 drives mem_req=0 next cycle, issues no ack, and leaves all flags clear.
REQ-048 Bench SHALL check that a second cpu_req while the first is pending yields exactly one memory access and one ack.
REQ-049 Bench SHALL check that, with MEM_ARB_LOADER_EN undefined, ld_req pulses never generate mem_req.

Source files
------------

// File: rtl/amstrad_mem_pkg.sv
// Shared types and default widths for the Amstrad memory arbiter slice.
package amstrad_mem_pkg;
    localparam int MEM_AW_DEF = 23;
    localparam int MEM_DW     = 8;

    // Requester encoding doubles as the bit index of the one-hot grant vector.
    typedef enum logic [1:0] {
        REQ_VID = 2'd0,
        REQ_CPU = 2'd1,
        REQ_LD  = 2'd2
    } req_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/mem_arb_prio.sv
// Combinational winner select: video > CPU > loader, with a starved loader jumping ahead of the CPU.
module mem_arb_prio
    import amstrad_mem_pkg::*;
(
    input  logic       vid_pend,
    input  logic       cpu_pend,
    input  logic       ld_pend,
    input  logic       starve,
    output logic [2:0] grant
);
    always_comb begin
        grant = '0;
        if (vid_pend)
            grant[REQ_VID] = 1'b1;
        else if (ld_pend && starve)
            grant[REQ_LD] = 1'b1;
        else if (cpu_pend)
            grant[REQ_CPU] = 1'b1;
        else if (ld_pend)
            grant[REQ_LD] = 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Three-port single-outstanding memory arbiter (video, CPU, loader).
// Loader port and starvation promotion are built only when MEM_ARB_LOADER_EN is defined.
module mem_arbiter
    import amstrad_mem_pkg::*;
#(
    parameter int AW         = MEM_AW_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [AW-1:0]     vid_addr,
    output logic              vid_ack,
    output logic [MEM_DW-1:0] vid_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [MEM_DW-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [MEM_DW-1:0] cpu_dout,
    input  logic              ld_req,
    input  logic [AW-1:0]     ld_addr,
    input  logic [MEM_DW-1:0] ld_din,
    output logic              ld_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [MEM_DW-1:0] mem_din,
    input  logic [MEM_DW-1:0] mem_dout,
    input  logic              mem_ready
);
    state_e            state, state_nxt;
    req_e              owner;
    logic              vid_pend, cpu_pend, ld_pend, starve;
    logic [AW-1:0]     vid_addr_q, cpu_addr_q, ld_addr_q;
    logic [MEM_DW-1:0] cpu_din_q, ld_din_q;
    logic              cpu_we_q;
    logic [2:0]        grant;
    logic              any_pend, grant_en, complete;

    assign any_pend = vid_pend | cpu_pend | ld_pend;
    assign grant_en = (state == ST_IDLE) && any_pend;
    assign complete = (state == ST_BUSY) && mem_ready;

    mem_arb_prio u_prio (
        .vid_pend (vid_pend),
        .cpu_pend (cpu_pend),
        .ld_pend  (ld_pend),
        .starve   (starve),
        .grant    (grant)
    );

    always_ff @(posedge CLK) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_pend)  state_nxt = ST_BUSY;
            ST_BUSY: if (mem_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A grant clears the flag; a pulse is only taken while the flag is clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            vid_pend   <= 1'b0;
            vid_addr_q <= '0;
        end else if (grant_en && grant[REQ_VID]) begin
            vid_pend <= 1'b0;
        end else if (vid_req && !vid_pend) begin
            vid_pend   <= 1'b1;
            vid_addr_q <= vid_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cpu_pend   <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
        end else if (grant_en && grant[REQ_CPU]) begin
            cpu_pend <= 1'b0;
        end else if (cpu_req && !cpu_pend) begin
            cpu_pend   <= 1'b1;
            cpu_we_q   <= cpu_we;
            cpu_addr_q <= cpu_addr;
            cpu_din_q  <= cpu_din;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            owner    <= REQ_VID;
        end else if (grant_en) begin
            mem_req <= 1'b1;
            if (grant[REQ_VID]) begin
                owner    <= REQ_VID;
                mem_addr <= vid_addr_q;
                mem_we   <= 1'b0;
                mem_din  <= '0;
            end else if (grant[REQ_CPU]) begin
                owner    <= REQ_CPU;
                mem_addr <= cpu_addr_q;
                mem_we   <= cpu_we_q;
                mem_din  <= cpu_din_q;
            end else begin
                owner    <= REQ_LD;
                mem_addr <= ld_addr_q;
                mem_we   <= 1'b1;
                mem_din  <= ld_din_q;
            end
        end else if (complete) begin
            mem_req <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            vid_dout <= '0;
            cpu_dout <= '0;
        end else begin
            vid_ack <= complete && (owner == REQ_VID);
            cpu_ack <= complete && (owner == REQ_CPU);
            if (complete && owner == REQ_VID)
                vid_dout <= mem_dout;
            if (complete && owner == REQ_CPU && !mem_we)
                cpu_dout <= mem_dout;
        end
    end

`ifdef MEM_ARB_LOADER_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign starve = (starve_cnt >= SW'(STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (reset) begin
            ld_pend   <= 1'b0;
            ld_addr_q <= '0;
            ld_din_q  <= '0;
        end else if (grant_en && grant[REQ_LD]) begin
            ld_pend <= 1'b0;
        end else if (ld_req && !ld_pend) begin
            ld_pend   <= 1'b1;
            ld_addr_q <= ld_addr;
            ld_din_q  <= ld_din;
        end
    end

    // Count grants that overtook a waiting loader; saturates so the promotion sticks.
    always_ff @(posedge CLK) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant_en && grant[REQ_LD])
            starve_cnt <= '0;
        else if (grant_en && ld_pend && !starve)
            starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset) ld_ack <= 1'b0;
        else       ld_ack <= complete && (owner == REQ_LD);
    end
`else
    logic unused_ld;
    assign unused_ld = ^{ld_req, ld_addr, ld_din, STARVE_MAX[0]};
    assign ld_pend   = 1'b0;
    assign ld_addr_q = '0;
    assign ld_din_q  = '0;
    assign starve    = 1'b0;
    assign ld_ack    = 1'b0;
`endif
endmodule
